// File: rtl/t65_sys_pkg.sv
// t65_sys_ctrl shared definitions.
// Strobe selects, decoder region, watchdog states, helpers.
package t65_sys_pkg;

  localparam logic [1:0] SEL_IRQACK = 2'b00;
  localparam logic [1:0] SEL_VGGO   = 2'b01;
  localparam logic [1:0] SEL_WDCLR  = 2'b10;
  localparam logic [1:0] SEL_VGRST  = 2'b11;

  localparam logic [2:0] SD_REGION_DEF = 3'b010;

  typedef enum logic {
    WD_RUN,
    WD_TRIP
  } wd_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/t65_sys_ctrl_tick_counter.sv
// Tick-driven modulo counter; pulses o_wrap on the tick
// that returns it to zero. Clear wins over a tick.
module t65_tick_counter #(
  parameter int PERIOD = 12,
  parameter int W      = $clog2(PERIOD)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_clr,
  output logic o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(PERIOD - 1));
  assign o_wrap = i_tick & ~i_clr & w_last;

  // count ticks 0..PERIOD-1, hold at zero while cleared
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t65_sys_ctrl.sv
// T65 control strobes, frame IRQ timer and watchdog.
// Strobes are decoded at CPU cycle end and last one clock.
module t65_sys_ctrl
  import t65_sys_pkg::*;
#(
  parameter int          IRQ_PERIOD    = 12,
  parameter int          WD_LIMIT      = 128,
  parameter int          WD_RST_CYCLES = 16,
  parameter int          WD_EN         = 1,
  parameter int          ACK_ON_WDCLR  = 1,
  parameter logic [2:0]  SD_REGION     = SD_REGION_DEF
) (
  input  logic        clk_6MHz,
  input  logic        RESET,
  input  logic        tick_3kHz,
  input  logic [15:0] A6502,
  input  logic        R_Wn,
  input  logic        Phi2,
  output logic        VGGO_n,
  output logic        VGRST_n,
  output logic        WDCLR_n,
  output logic        IRQ_n,
  output logic [3:0]  irq_overrun,
  output logic        wd_reset,
  output logic [3:0]  wd_trips
);

  localparam int   TW       = (WD_RST_CYCLES > 1) ? $clog2(WD_RST_CYCLES) : 1;
  localparam logic L_WD_EN  = (WD_EN != 0);
  localparam logic L_ACK_WD = (ACK_ON_WDCLR != 0);

  logic          r_phi2;
  logic [4:0]    r_addr;
  logic          r_rwn;
  logic          r_ack;
  logic          r_vggo_n;
  logic          r_vgrst_n;
  logic          r_wdclr_n;
  logic          r_pending;
  logic [3:0]    r_overrun;
  wd_state_t     r_state;
  logic          r_wd_reset;
  logic [3:0]    r_trips;
  logic [TW-1:0] r_tcnt;

  logic       w_end;
  logic       w_hit;
  logic [1:0] w_sel;
  logic       w_wdclr;
  logic       w_ack;
  logic       w_trip;
  logic       w_hold;
  logic       w_irq_wrap;
  logic       w_wd_wrap;
  logic       w_wd_clr;
  logic       w_unused_addr;

  assign w_unused_addr = ^A6502[10:0];

  assign w_end   = r_phi2 & ~Phi2;
  assign w_hit   = w_end & ~r_rwn & (r_addr[4:2] == SD_REGION);
  assign w_sel   = r_addr[1:0];
  assign w_wdclr = ~r_wdclr_n;
  assign w_ack   = r_ack | (L_ACK_WD & w_wdclr);
  assign w_trip  = (r_state == WD_TRIP);
  assign w_hold  = w_trip | w_wd_wrap;
  assign w_wd_clr = ~L_WD_EN | w_trip | w_wdclr;

  assign VGGO_n      = r_vggo_n;
  assign VGRST_n     = r_vgrst_n;
  assign WDCLR_n     = r_wdclr_n;
  assign IRQ_n       = ~r_pending;
  assign irq_overrun = r_overrun;
  assign wd_reset    = r_wd_reset;
  assign wd_trips    = r_trips;

  t65_tick_counter #(
    .PERIOD (IRQ_PERIOD)
  ) u_irq_cnt (
    .i_clk  (clk_6MHz),
    .i_rst  (RESET),
    .i_tick (tick_3kHz),
    .i_clr  (w_hold),
    .o_wrap (w_irq_wrap)
  );

  t65_tick_counter #(
    .PERIOD (WD_LIMIT)
  ) u_wd_cnt (
    .i_clk  (clk_6MHz),
    .i_rst  (RESET),
    .i_tick (tick_3kHz),
    .i_clr  (w_wd_clr),
    .o_wrap (w_wd_wrap)
  );

  // capture bus during Phi2, decode one strobe at cycle end
  always_ff @(posedge clk_6MHz or posedge RESET) begin
    if (RESET) begin
      r_phi2    <= 1'b0;
      r_addr    <= '0;
      r_rwn     <= 1'b1;
      r_ack     <= 1'b0;
      r_vggo_n  <= 1'b1;
      r_vgrst_n <= 1'b1;
      r_wdclr_n <= 1'b1;
    end else begin
      r_phi2 <= Phi2;
      if (Phi2) begin
        r_addr <= A6502[15:11];
        r_rwn  <= R_Wn;
      end
      r_ack     <= w_hit & (w_sel == SEL_IRQACK);
      r_vggo_n  <= ~(w_hit & (w_sel == SEL_VGGO));
      r_wdclr_n <= ~(w_hit & (w_sel == SEL_WDCLR));
      r_vgrst_n <= ~(w_hit & (w_sel == SEL_VGRST));
    end
  end

  // IRQ pending flag and overrun count; wrap beats a same-cycle ack
  always_ff @(posedge clk_6MHz or posedge RESET) begin
    if (RESET) begin
      r_pending <= 1'b0;
      r_overrun <= '0;
    end else if (w_hold) begin
      r_pending <= 1'b0;
    end else if (w_irq_wrap) begin
      r_pending <= 1'b1;
      if (r_pending && !w_ack)
        r_overrun <= sat_inc4(r_overrun);
    end else if (w_ack) begin
      r_pending <= 1'b0;
    end
  end

  // watchdog: trip on limit, then a fixed-width reset pulse
  always_ff @(posedge clk_6MHz or posedge RESET) begin
    if (RESET) begin
      r_state    <= WD_RUN;
      r_wd_reset <= 1'b0;
      r_trips    <= '0;
      r_tcnt     <= '0;
    end else begin
      unique case (r_state)
        WD_RUN: begin
          if (w_wd_wrap) begin
            r_state    <= WD_TRIP;
            r_wd_reset <= 1'b1;
            r_tcnt     <= '0;
            r_trips    <= sat_inc4(r_trips);
          end
        end
        WD_TRIP: begin
          if (r_tcnt == TW'(WD_RST_CYCLES - 1)) begin
            r_state    <= WD_RUN;
            r_wd_reset <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: begin
          r_state    <= WD_RUN;
          r_wd_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule
